lvds_link_packer: RTL and testbench

- Parametrised successor to the fixed 24-bit LVDS bit-mapper.
- Packs RGB pixels plus hs/vs/de into 7-bit-per-lane LVDS transmitter words.
- Supports single or dual (odd/even pixel) links, 18/24 bpp, and run-time VESA/JEIDA mapping.
- Registered output; sits between the video timing/pixel pipeline and the 7:1 serialiser primitives.

---
 rtl/lvds_pkg.sv | 57 +++++
 rtl/lvds_pixel_map.sv | 19 +
 rtl/lvds_link_packer.sv | 134 +++++++++++++
 tb/tb_lvds_link_packer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// Shared constants, map-mode type and single-pixel lane mapper for the LVDS link packer.
package lvds_pkg;

  localparam int unsigned LANE_BITS  = 7;
  localparam int unsigned LINK_LANES = 4;
  localparam int unsigned LINK_BITS  = LANE_BITS * LINK_LANES;

  typedef enum logic {
    MAP_VESA  = 1'b0,
    MAP_JEIDA = 1'b1
  } map_mode_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StHoldA = 1'b1
  } pair_state_e;

  // Returns {lane3, lane2, lane1, lane0}; bit 6 of each lane is transmitted first.
  function automatic logic [LINK_BITS-1:0] map_pixel(
    input logic [23:0] rgb,
    input logic        hs,
    input logic        vs,
    input logic        de,
    input map_mode_e   mode,
    input int unsigned bpc
  );
    logic [7:0]           r;
    logic [7:0]           g;
    logic [7:0]           b;
    logic [LANE_BITS-1:0] l0;
    logic [LANE_BITS-1:0] l1;
    logic [LANE_BITS-1:0] l2;
    logic [LANE_BITS-1:0] l3;
    r = rgb[7:0];
    g = rgb[15:8];
    b = rgb[23:16];
    if (bpc == 6) begin
      // 6-bit colour is the top six bits of each channel, laid out on VESA lanes 0-2
      l0 = {g[2], r[7:2]};
      l1 = {b[3:2], g[7:3]};
      l2 = {de, vs, hs, b[7:4]};
      l3 = '0;
    end else if (mode == MAP_JEIDA) begin
      l0 = {g[2], r[7:2]};
      l1 = {b[3:2], g[7:3]};
      l2 = {de, vs, hs, b[7:4]};
      l3 = {1'b0, r[1:0], g[1:0], b[1:0]};
    end else begin
      l0 = {g[0], r[5:0]};
      l1 = {b[1:0], g[5:1]};
      l2 = {de, vs, hs, b[5:2]};
      l3 = {1'b0, r[7:6], g[7:6], b[7:6]};
    end
    return {l3, l2, l1, l0};
  endfunction

endpackage

// File: rtl/lvds_pixel_map.sv
// Combinational mapper of one pixel plus syncs onto the four 7-bit lanes of one link.
module lvds_pixel_map
  import lvds_pkg::*;
#(
  parameter int unsigned BPC = 8
) (
  input  logic [23:0]          i_rgb,
  input  logic                 i_hs,
  input  logic                 i_vs,
  input  logic                 i_de,
  input  logic                 i_mode_jeida,
  output logic [LINK_BITS-1:0] o_word
);

  always_comb begin
    o_word = map_pixel(i_rgb, i_hs, i_vs, i_de, map_mode_e'(i_mode_jeida), BPC);
  end

endmodule

// File: rtl/lvds_link_packer.sv
// Packs RGB pixels and syncs into single- or dual-link LVDS lane words with a per-line map
// mode latch and odd/even pixel pairing.
module lvds_link_packer
  import lvds_pkg::*;
#(
  parameter int unsigned NUM_LINKS = 2,
  parameter int unsigned BPC       = 8,
  parameter int unsigned LANES     = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic                                 i_pix_valid,
  input  logic [23:0]                          i_rgb,
  input  logic                                 i_hs,
  input  logic                                 i_vs,
  input  logic                                 i_de,
  input  logic                                 i_mode_jeida,
  output logic                                 o_out_valid,
  output logic [LANE_BITS*LANES*NUM_LINKS-1:0] o_lvds_out,
  output logic                                 o_odd_line_err
);

  localparam int unsigned LinkBits = LANE_BITS * LANES;

  map_mode_e                     r_mode;
  logic                          r_prev_de;
  logic                          r_out_valid;
  logic                          r_odd_line_err;
  logic [LinkBits*NUM_LINKS-1:0] r_lvds_out;
  logic                          w_de_rise;
  map_mode_e                     w_mode;
  logic [LINK_BITS-1:0]          w_word;

  // A line's first pixel already uses the mode presented with it.
  assign w_de_rise = i_pix_valid & i_de & ~r_prev_de;
  assign w_mode    = w_de_rise ? map_mode_e'(i_mode_jeida) : r_mode;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mode    <= MAP_VESA;
      r_prev_de <= 1'b0;
    end else if (i_pix_valid) begin
      r_prev_de <= i_de;
      if (w_de_rise) begin
        r_mode <= map_mode_e'(i_mode_jeida);
      end
    end
  end

  lvds_pixel_map #(
    .BPC (BPC)
  ) u_pixel_map (
    .i_rgb        (i_rgb),
    .i_hs         (i_hs),
    .i_vs         (i_vs),
    .i_de         (i_de),
    .i_mode_jeida (w_mode == MAP_JEIDA),
    .o_word       (w_word)
  );

  if (NUM_LINKS == 1) begin : g_single
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_out_valid    <= 1'b0;
        r_lvds_out     <= '0;
        r_odd_line_err <= 1'b0;
      end else begin
        r_out_valid    <= i_pix_valid;
        r_odd_line_err <= 1'b0;
        if (i_pix_valid) begin
          r_lvds_out <= w_word;
        end
      end
    end
  end else begin : g_dual
    pair_state_e          r_state;
    logic [LINK_BITS-1:0] r_hold_word;
    logic                 r_hold_hs;
    logic                 r_hold_vs;
    logic                 r_hold_de;
    logic [LINK_BITS-1:0] w_blank;

    // Fills link B when a line boundary leaves the held pixel without a partner.
    assign w_blank = map_pixel(24'h000000, r_hold_hs, r_hold_vs, 1'b0, MAP_VESA, BPC);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_state        <= StEmpty;
        r_hold_word    <= '0;
        r_hold_hs      <= 1'b0;
        r_hold_vs      <= 1'b0;
        r_hold_de      <= 1'b0;
        r_out_valid    <= 1'b0;
        r_lvds_out     <= '0;
        r_odd_line_err <= 1'b0;
      end else begin
        r_out_valid    <= 1'b0;
        r_odd_line_err <= 1'b0;
        if (i_pix_valid) begin
          case (r_state)
            StEmpty: begin
              r_hold_word <= w_word;
              r_hold_hs   <= i_hs;
              r_hold_vs   <= i_vs;
              r_hold_de   <= i_de;
              r_state     <= StHoldA;
            end
            StHoldA: begin
              r_out_valid <= 1'b1;
              if (i_de == r_hold_de) begin
                r_lvds_out <= {w_word, r_hold_word};
                r_state    <= StEmpty;
              end else begin
                // Line boundary: flush the held pixel and start a new pair with this one.
                r_lvds_out     <= {w_blank, r_hold_word};
                r_odd_line_err <= r_hold_de;
                r_hold_word    <= w_word;
                r_hold_hs      <= i_hs;
                r_hold_vs      <= i_vs;
                r_hold_de      <= i_de;
              end
            end
            default: r_state <= StEmpty;
          endcase
        end
      end
    end
  end

  assign o_out_valid    = r_out_valid;
  assign o_lvds_out     = r_lvds_out;
  assign o_odd_line_err = r_odd_line_err;

endmodule

// File: tb/tb_lvds_link_packer.sv
// Directed bench for lvds_link_packer: single-link 24 bpp, single-link 18 bpp and dual-link builds.
module tb_lvds_link_packer;

  logic        clk;
  logic        reset_n;
  logic        pv;
  logic [23:0] rgb;
  logic        hs;
  logic        vs;
  logic        de;
  logic        mj;

  logic        s_valid;
  logic [27:0] s_word;
  logic        s_err;
  logic        s6_valid;
  logic [27:0] s6_word;
  logic        s6_err;
  logic        d_valid;
  logic [55:0] d_word;
  logic        d_err;

  int n_pass;
  int n_total;

  typedef struct packed {
    logic        pv;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        mj;
    logic        exp_v;
    logic [27:0] exp_w;
    logic [27:0] exp_w6;
  } vec_t;

  vec_t vecs [12];

  lvds_link_packer #(.NUM_LINKS(1), .BPC(8), .LANES(4)) u_single (
    .i_clk(clk), .i_reset_n(reset_n), .i_pix_valid(pv), .i_rgb(rgb), .i_hs(hs), .i_vs(vs),
    .i_de(de), .i_mode_jeida(mj), .o_out_valid(s_valid), .o_lvds_out(s_word),
    .o_odd_line_err(s_err)
  );

  lvds_link_packer #(.NUM_LINKS(1), .BPC(6), .LANES(4)) u_single6 (
    .i_clk(clk), .i_reset_n(reset_n), .i_pix_valid(pv), .i_rgb(rgb), .i_hs(hs), .i_vs(vs),
    .i_de(de), .i_mode_jeida(mj), .o_out_valid(s6_valid), .o_lvds_out(s6_word),
    .o_odd_line_err(s6_err)
  );

  lvds_link_packer #(.NUM_LINKS(2), .BPC(8), .LANES(4)) u_dual (
    .i_clk(clk), .i_reset_n(reset_n), .i_pix_valid(pv), .i_rgb(rgb), .i_hs(hs), .i_vs(vs),
    .i_de(de), .i_mode_jeida(mj), .o_out_valid(d_valid), .o_lvds_out(d_word),
    .o_odd_line_err(d_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] c, input logic h, input logic vv,
                       input logic d);
    pv  = v;
    rgb = c;
    hs  = h;
    vs  = vv;
    de  = d;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_dual(input string name, input logic exp_v, input logic [55:0] exp_w,
                          input logic exp_e);
    chk({name, "_valid"}, 64'(d_valid), 64'(exp_v));
    chk({name, "_err"}, 64'(d_err), 64'(exp_e));
    if (exp_v) begin
      chk({name, "_word"}, 64'(d_word), 64'(exp_w));
    end
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    mj      = 1'b0;
    reset_n = 1'b1;
    drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);

    //             pv    rgb         hs    vs    de    mj    v     single      18 bpp
    vecs[0]  = '{1'b1, 24'hC08041, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 28'h3780001, 28'h01B0810};
    vecs[1]  = '{1'b1, 24'hC08041, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 28'h3780001, 28'h01B0810};
    vecs[2]  = '{1'b0, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 28'h3780001, 28'h01B0810};
    vecs[3]  = '{1'b1, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 28'h0040000, 28'h0040000};
    vecs[4]  = '{1'b1, 24'hC08041, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 28'h21B0810, 28'h01B0810};
    vecs[5]  = '{1'b1, 24'h000F00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 28'h19C00C0, 28'h01C00C0};
    vecs[6]  = '{1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0000000, 28'h0000000};
    vecs[7]  = '{1'b1, 24'h000F00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 28'h01C03C0, 28'h01C00C0};
    vecs[8]  = '{1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 28'h7F3FFFF, 28'h013FFFF};
    vecs[9]  = '{1'b1, 24'h5A3C96, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 28'h431AF16, 28'h01163E5};
    vecs[10] = '{1'b1, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 28'h0000000, 28'h0000000};
    vecs[11] = '{1'b1, 24'h5A3C96, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 28'h45163E5, 28'h01163E5};

    #2;
    reset_n = 1'b0;
    #2;
    chk("rst_single_valid", 64'(s_valid), 64'd0);
    chk("rst_single_word", 64'(s_word), 64'd0);
    chk("rst_single_err", 64'(s_err), 64'd0);
    chk("rst_s6_valid", 64'(s6_valid), 64'd0);
    chk("rst_s6_word", 64'(s6_word), 64'd0);
    chk("rst_dual_valid", 64'(d_valid), 64'd0);
    chk("rst_dual_word", 64'(d_word), 64'd0);
    chk("rst_dual_err", 64'(d_err), 64'd0);
    tick;
    tick;
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      mj = vecs[i].mj;
      drive(vecs[i].pv, vecs[i].rgb, vecs[i].hs, vecs[i].vs, vecs[i].de);
      tick;
      chk($sformatf("single_valid[%0d]", i), 64'(s_valid), 64'(vecs[i].exp_v));
      chk($sformatf("single_word[%0d]", i), 64'(s_word), 64'(vecs[i].exp_w));
      chk($sformatf("s6_word[%0d]", i), 64'(s6_word), 64'(vecs[i].exp_w6));
    end

    // Dual link: four active pixels, two pairs
    mj = 1'b0;
    do_reset;
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b1); tick; chk_dual("p0_hold", 1'b0, 56'h0, 1'b0);
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b1); tick;
    chk_dual("p1_pair", 1'b1, {28'h7F3FFFF, 28'h0100000}, 1'b0);
    drive(1'b1, 24'h0000FF, 1'b0, 1'b0, 1'b1); tick; chk_dual("p2_hold", 1'b0, 56'h0, 1'b0);
    drive(1'b1, 24'h00FF00, 1'b0, 1'b0, 1'b1); tick;
    chk_dual("p3_pair", 1'b1, {28'h1900FC0, 28'h610003F}, 1'b0);

    // Odd-length line: third pixel flushed against a blank word
    do_reset;
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b1); tick; chk_dual("o0_hold", 1'b0, 56'h0, 1'b0);
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b1); tick;
    chk_dual("o1_pair", 1'b1, {28'h7F3FFFF, 28'h0100000}, 1'b0);
    drive(1'b1, 24'h0000FF, 1'b0, 1'b1, 1'b1); tick; chk_dual("o2_hold", 1'b0, 56'h0, 1'b0);
    drive(1'b1, 24'h000000, 1'b1, 1'b0, 1'b0); tick;
    chk_dual("odd_flush", 1'b1, {28'h0080000, 28'h618003F}, 1'b1);
    drive(1'b1, 24'h000000, 1'b1, 1'b0, 1'b0); tick;
    chk_dual("blank_pair", 1'b1, {28'h0040000, 28'h0040000}, 1'b0);
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b1); tick; chk_dual("line2_hold", 1'b0, 56'h0, 1'b0);
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b1); tick;
    chk_dual("line2_pair", 1'b1, {28'h0100000, 28'h7F3FFFF}, 1'b0);

    // Unpaired blanking pixel flushed by a de rise, without an error pulse
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b0); tick; chk_dual("bl_hold", 1'b0, 56'h0, 1'b0);
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b1); tick;
    chk_dual("rise_flush", 1'b1, 56'h0, 1'b0);
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b1); tick;
    chk_dual("rise_pair", 1'b1, {28'h7F3FFFF, 28'h0100000}, 1'b0);

    // Stall while holding link A
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b1); tick; chk_dual("st_hold", 1'b0, 56'h0, 1'b0);
    drive(1'b0, 24'h000000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_dual($sformatf("stall[%0d]", i), 1'b0, 56'h0, 1'b0);
    end
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b1); tick;
    chk_dual("stall_pair", 1'b1, {28'h0100000, 28'h7F3FFFF}, 1'b0);

    // Reset while holding link A: held pixel must vanish
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b1); tick; chk_dual("rh_hold", 1'b0, 56'h0, 1'b0);
    drive(1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    chk("async_rst_valid", 64'(d_valid), 64'd0);
    chk("async_rst_word", 64'(d_word), 64'd0);
    tick;
    tick;
    reset_n = 1'b1;
    drive(1'b1, 24'h000000, 1'b0, 1'b0, 1'b1); tick; chk_dual("post_rst_hold", 1'b0, 56'h0, 1'b0);
    drive(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b1); tick;
    chk_dual("post_rst_pair", 1'b1, {28'h7F3FFFF, 28'h0100000}, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
